zerosoc_pinmux: RTL

- Parametrised pad multiplexer and controller between the padring and the SoC core.
- Replaces hard-wired GPIO/UART/clock pad assignments with register-programmable per-pad function selection.
- Adds per-pad input synchronisation, optional debounce, input inversion, drive config, and a write-once lock.
- Drives the padring din/dout/ie/oen/cfg buses; sits beside the SoC on a simple single-cycle register bus.

---
 rtl/zerosoc_pinmux.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/zerosoc_pinmux.sv
// Pad multiplexer between padring and SoC core: per-pad function select, input
// synchronisation with optional debounce and inversion, pad config, write-once lock.
module zerosoc_pinmux #(
  parameter int                NUM_PADS  = 36,
  parameter int                NUM_FUNC  = 4,
  parameter int                CFG_W     = 8,
  parameter int                DEB_W     = 8,
  parameter logic [DEB_W-1:0]  DEB_RESET = 8'd16,
  parameter logic              ALT_IDLE  = 1'b1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           reg_req_i,
  input  logic                           reg_we_i,
  input  logic [7:0]                     reg_addr_i,
  input  logic [31:0]                    reg_wdata_i,
  output logic [31:0]                    reg_rdata_o,
  output logic                           reg_ack_o,
  input  logic [NUM_PADS-1:0]            pad_din_i,
  output logic [NUM_PADS-1:0]            pad_dout_o,
  output logic [NUM_PADS-1:0]            pad_oen_o,
  output logic [NUM_PADS-1:0]            pad_ie_o,
  output logic [NUM_PADS*CFG_W-1:0]      pad_cfg_o,
  input  logic [NUM_PADS-1:0]            gpio_o,
  input  logic [NUM_PADS-1:0]            gpio_en_i,
  output logic [NUM_PADS-1:0]            gpio_i,
  input  logic [NUM_PADS*(NUM_FUNC-1)-1:0] alt_out_i,
  input  logic [NUM_PADS*(NUM_FUNC-1)-1:0] alt_oe_i,
  output logic [NUM_PADS*(NUM_FUNC-1)-1:0] alt_in_o
);

  localparam int         FW        = NUM_FUNC - 1;
  localparam int         PW        = 4 + CFG_W;
  localparam logic [7:0] ADDR_DEB  = 8'(NUM_PADS);
  localparam logic [7:0] ADDR_LOCK = 8'(NUM_PADS + 1);

  logic [PW-1:0]       padctl_q [NUM_PADS];
  logic [PW-1:0]       padctl_d [NUM_PADS];
  logic [DEB_W-1:0]    debthr_q, debthr_d;
  logic                lock_q, lock_d;
  logic                ack_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                wr_en, rd_en;

  logic [NUM_PADS-1:0] sync1_q, sync2_q;
  logic [NUM_PADS-1:0] filt_q, filt_d;
  logic [DEB_W-1:0]    cnt_q [NUM_PADS];
  logic [DEB_W-1:0]    cnt_d [NUM_PADS];
  logic [NUM_PADS-1:0] s_in;
  logic [1:0]          func [NUM_PADS];
  logic [NUM_PADS-1:0] deb_en, in_inv;

  logic [NUM_PADS-1:0] dout_q, dout_d;
  logic [NUM_PADS-1:0] oen_q, oen_d;
  logic [NUM_PADS-1:0] ie_q;

  logic                unused_wdata;
  assign unused_wdata = ^reg_wdata_i[31:PW];

  assign wr_en = reg_req_i & reg_we_i;
  assign rd_en = reg_req_i & ~reg_we_i;

  // Register file: writes to PADCTL/DEBTHR are dropped while locked, still acked.
  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      padctl_d[p] = padctl_q[p];
    end
    debthr_d = debthr_q;
    lock_d   = lock_q;
    rdata_d  = '0;

    if (wr_en && !lock_q) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (reg_addr_i == 8'(p)) padctl_d[p] = reg_wdata_i[PW-1:0];
      end
      if (reg_addr_i == ADDR_DEB) debthr_d = reg_wdata_i[DEB_W-1:0];
    end
    if (wr_en && reg_addr_i == ADDR_LOCK && reg_wdata_i[0]) lock_d = 1'b1;

    if (rd_en) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (reg_addr_i == 8'(p)) rdata_d = 32'(padctl_q[p]);
      end
      if (reg_addr_i == ADDR_DEB)  rdata_d = 32'(debthr_q);
      if (reg_addr_i == ADDR_LOCK) rdata_d = {31'b0, lock_q};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        padctl_q[p] <= '0;
      end
      debthr_q <= DEB_RESET;
      lock_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        padctl_q[p] <= padctl_d[p];
      end
      debthr_q <= debthr_d;
      lock_q   <= lock_d;
      ack_q    <= reg_req_i;
      rdata_q  <= rdata_d;
    end
  end

  assign reg_ack_o   = ack_q;
  assign reg_rdata_o = rdata_q;

  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      func[p]   = padctl_q[p][1:0];
      deb_en[p] = padctl_q[p][2];
      in_inv[p] = padctl_q[p][3];
      s_in[p]   = sync2_q[p] ^ padctl_q[p][3];
    end
  end

  // Debounce: the filter follows s only after it has disagreed for more than
  // DEBTHR consecutive cycles; the count is held while debounce is disabled.
  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      filt_d[p] = filt_q[p];
      cnt_d[p]  = cnt_q[p];
      if (!deb_en[p]) begin
        filt_d[p] = s_in[p];
      end else if (s_in[p] == filt_q[p]) begin
        cnt_d[p] = '0;
      end else if (cnt_q[p] >= debthr_q) begin
        filt_d[p] = s_in[p];
        cnt_d[p]  = '0;
      end else begin
        cnt_d[p] = cnt_q[p] + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      for (int p = 0; p < NUM_PADS; p++) begin
        cnt_q[p] <= '0;
      end
    end else begin
      sync1_q <= pad_din_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      for (int p = 0; p < NUM_PADS; p++) begin
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  // Function values with no matching alternate fall through to GPIO.
  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      dout_d[p] = gpio_o[p];
      oen_d[p]  = ~gpio_en_i[p];
      for (int f = 1; f < NUM_FUNC; f++) begin
        if (func[p] == 2'(f)) begin
          dout_d[p] = alt_out_i[p*FW + f - 1];
          oen_d[p]  = ~alt_oe_i[p*FW + f - 1];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int f = 1; f < NUM_FUNC; f++) begin
        alt_in_o[p*FW + f - 1] = (func[p] == 2'(f)) ? filt_q[p] : ALT_IDLE;
      end
      pad_cfg_o[p*CFG_W +: CFG_W] = padctl_q[p][4 +: CFG_W];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q <= '0;
      oen_q  <= '1;
      ie_q   <= '1;
    end else begin
      dout_q <= dout_d;
      oen_q  <= oen_d;
      ie_q   <= oen_d;
    end
  end

  assign pad_dout_o = dout_q;
  assign pad_oen_o  = oen_q;
  assign pad_ie_o   = ie_q;
  assign gpio_i     = filt_q;

endmodule
